pipe_register_chain: RTL and testbench

- Parametrised multi-stage pipeline register: a chain of DEPTH register stages, each WIDTH bits wide, with a per-stage valid bit and valid/ready flow control.
- Successor to the single-stage scalable register. Adds depth, synchronous reset, back-pressure, bubble collapsing and flush.
- Sits between producer and consumer datapath blocks that need fixed-latency retiming with stall support.

---
 rtl/pipe_register_chain_pkg.sv | 13 +
 rtl/pipe_register_chain_stage.sv | 54 +++++
 rtl/pipe_register_chain.sv | 108 ++++++++++
 tb/tb_pipe_register_chain.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_register_chain_pkg.sv
// Shared definitions for the pipe_register_chain slice: default geometry
// and the helper that sizes the occupancy counter.
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to hold the values 0..depth inclusive.
    function automatic int countWidth(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_register_chain_stage.sv
// One pipeline stage: a valid bit plus a data register. The stage takes a
// new word whenever it is empty or its downstream neighbour can move, which
// is what lets bubbles collapse while the tail of the chain is stalled.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             upValid_i,
    input  logic [WIDTH-1:0] upData_i,
    input  logic             dnReady_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             ready_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign ready_o = !valid_q | dnReady_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Next state: flush drops the valid but keeps data; data only loads with a valid word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (FLUSH) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = upValid_i;
            if (upValid_i) begin
                data_d = upData_i;
            end
        end
    end

    // Stage registers with synchronous reset clearing both valid and data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pipe_register_chain.sv
// Multi-stage valid/ready pipeline register built from DEPTH pipe_stage
// instances. Ready ripples back combinationally from the consumer so a full
// chain still accepts a word in the same cycle one leaves.
// Optional feature macro: PIPE_COUNT_EN adds the registered COUNT output.
module pipe_register_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = countWidth(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] R
`ifdef PIPE_COUNT_EN
    ,
    output logic [CNT_W-1:0] COUNT
`endif
);

    // A zero-depth chain has no output stage and cannot be built.
    if (DEPTH < 1 || WIDTH < 1 || CNT_W < 1) begin : gParamCheck
        $error("pipe_register_chain: DEPTH and WIDTH must both be at least 1");
    end

    logic [DEPTH-1:0] stageValid;
    logic [DEPTH-1:0] stageReady;
    logic [WIDTH-1:0] stageData [DEPTH];

    assign IN_READY  = stageReady[0] & !FLUSH;
    assign OUT_VALID = stageValid[DEPTH-1];
    assign R         = stageData[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : gStage
        logic             upValid;
        logic [WIDTH-1:0] upData;
        logic             dnReady;

        if (i == 0) begin : gHead
            assign upValid = IN_VALID;
            assign upData  = DATA_IN;
        end else begin : gBody
            assign upValid = stageValid[i-1];
            assign upData  = stageData[i-1];
        end

        if (i == DEPTH - 1) begin : gTail
            assign dnReady = OUT_READY;
        end else begin : gInner
            assign dnReady = stageReady[i+1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) uStage (
            .CLK      (CLK),
            .RST      (RST),
            .FLUSH    (FLUSH),
            .upValid_i(upValid),
            .upData_i (upData),
            .dnReady_i(dnReady),
            .valid_o  (stageValid[i]),
            .data_o   (stageData[i]),
            .ready_o  (stageReady[i])
        );
    end

`ifdef PIPE_COUNT_EN
    logic             inTransfer;
    logic             outTransfer;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign inTransfer  = IN_VALID & IN_READY;
    assign outTransfer = OUT_VALID & OUT_READY;
    assign COUNT       = count_q;

    // Occupancy tracks transfers; simultaneous in and out cancel, flush empties.
    always_comb begin
        count_d = count_q;
        if (FLUSH) begin
            count_d = '0;
        end else begin
            case ({inTransfer, outTransfer})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_register_chain.sv
// Directed testbench for pipe_register_chain (WIDTH=8, DEPTH=4).
// COUNT checks are active only when PIPE_COUNT_EN is defined.
module tb_pipe_register_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             CLK;
    logic             RST;
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] DATA_IN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] R;
    logic [CNT_W-1:0] count;

    int compared   = 0;
    int mismatched = 0;

    pipe_register_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .FLUSH    (FLUSH),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .DATA_IN  (DATA_IN),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .R        (R)
`ifdef PIPE_COUNT_EN
        ,
        .COUNT    (count)
`endif
    );

`ifndef PIPE_COUNT_EN
    assign count = '0;
`endif

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int expected);
`ifdef PIPE_COUNT_EN
        checkOutput(tag, 32'(count), 32'(expected));
`endif
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic oRdy, input logic fl);
        IN_VALID  = v;
        DATA_IN   = d;
        OUT_READY = oRdy;
        FLUSH     = fl;
        #1;
    endtask

    initial begin
        int nextIn;
        int nextOut;

        // ---------------- reset ----------------
        RST = 1'b1;
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rstOutValid", 32'(OUT_VALID), 32'd0);
        checkOutput("rstR", 32'(R), 32'h00);
        checkOutput("rstInReady", 32'(IN_READY), 32'd1);
        checkCount("rstCount", 0);
        RST = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("postRstOutValid", 32'(OUT_VALID), 32'd0);

        // ---------------- latency ----------------
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("latE1", 32'(OUT_VALID), 32'd0);
        tick();
        checkOutput("latE2", 32'(OUT_VALID), 32'd0);
        tick();
        checkOutput("latE3", 32'(OUT_VALID), 32'd0);
        tick();
        checkOutput("latE4Valid", 32'(OUT_VALID), 32'd1);
        checkOutput("latE4Data", 32'(R), 32'h5A);
        tick();
        checkOutput("latE5Valid", 32'(OUT_VALID), 32'd0);
        checkCount("latCount", 0);

        // ---------------- back-pressure ----------------
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(1'b1, 8'(n), 1'b0, 1'b0);
            checkOutput("bpAccept", 32'(IN_READY), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("bpFullInReady", 32'(IN_READY), 32'd0);
        checkOutput("bpHeadValid", 32'(OUT_VALID), 32'd1);
        checkOutput("bpHeadData", 32'(R), 32'h01);
        checkCount("bpFullCount", 4);
        tick();
        checkOutput("bpStallData", 32'(R), 32'h01);
        checkCount("bpStallCount", 4);

        nextIn  = 5;
        nextOut = 1;
        for (int cyc = 0; cyc < 20 && nextOut <= 6; cyc++) begin
            applyStimulus(nextIn <= 6, 8'(nextIn), 1'b1, 1'b0);
            if (OUT_VALID) begin
                checkOutput("bpDrainData", 32'(R), 32'(nextOut));
                nextOut++;
            end
            if (IN_VALID && IN_READY) nextIn++;
            tick();
        end
        checkOutput("bpDrainTotal", 32'(nextOut), 32'd7);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bpEmptyAfter", 32'(OUT_VALID), 32'd0);
        checkCount("bpEmptyCount", 0);

        // ---------------- bubble collapse ----------------
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("bubHeadValid", 32'(OUT_VALID), 32'd1);
        checkOutput("bubHeadData", 32'(R), 32'h11);
        checkCount("bubTwoCount", 2);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("bubAccept3", 32'(IN_READY), 32'd1);
        tick();
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
        checkOutput("bubAccept4", 32'(IN_READY), 32'd1);
        tick();
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("bubFullInReady", 32'(IN_READY), 32'd0);
        checkCount("bubFullCount", 4);

        // ---------------- flush ----------------
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flPopData", 32'(R), 32'h11);
        tick();
        checkOutput("flThreeHead", 32'(R), 32'h22);
        checkCount("flThreeCount", 3);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        checkOutput("flInReady", 32'(IN_READY), 32'd0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flOutValid", 32'(OUT_VALID), 32'd0);
        checkOutput("flDataKept", 32'(R), 32'h22);
        checkCount("flCount", 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("flNoFF", 32'(OUT_VALID), 32'd0);
        end

        // ---------------- full pass-through ----------------
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b1, 8'(8'hA0 + n), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ptFullInReady", 32'(IN_READY), 32'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'(8'hB0 + k), 1'b1, 1'b0);
            checkOutput("ptInReady", 32'(IN_READY), 32'd1);
            checkOutput("ptOutValid", 32'(OUT_VALID), 32'd1);
            checkOutput("ptData", 32'(R),
                        (k < 4) ? 32'(8'hA0 + k) : 32'(8'hB0 + k - 4));
            checkCount("ptCount", 4);
            tick();
        end
        checkCount("ptCountEnd", 4);

        // ---------------- reset mid-operation ----------------
        RST = 1'b1;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("midRstValid", 32'(OUT_VALID), 32'd0);
        checkOutput("midRstData", 32'(R), 32'h00);
        checkCount("midRstCount", 0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("midRstE3", 32'(OUT_VALID), 32'd0);
        tick();
        checkOutput("midRstE4Valid", 32'(OUT_VALID), 32'd1);
        checkOutput("midRstE4Data", 32'(R), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
